// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states: free-running issue, or holding EX for a mult/div.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

    // Architectural zero register: writes to it are discarded, so it never
    // produces a true data dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // ID_EX control bundle; a bubble is this bundle with every field cleared.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        reg_dst:    1'b0,
        branch:     1'b0,
        alu_op:     4'd0
    };

    // True when a produced register is a real (non-$0) match for a source.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [4:0]       EX_WriteReg;
    logic             EX_MulDiv;
    logic             EX_BranchTaken;

    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Bubble;
    logic             EX_Hold;
    logic             Busy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_WriteReg, EX_MulDiv, EX_BranchTaken,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, Busy, StallCount
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_WriteReg, EX_MulDiv, EX_BranchTaken,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, Busy, StallCount
    );
endinterface

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source of the
// instruction in ID forces a one-cycle stall. $0 never matches.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_write_reg_i,
    output logic       hazard_o
);

    // rt only counts when the ID instruction actually reads it as a source.
    assign hazard_o = ex_mem_read_i &&
                      (reg_match(ex_write_reg_i, id_rs_i) ||
                       (id_uses_rt_i && reg_match(ex_write_reg_i, id_rt_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken
// branch squash, multi-cycle mult/div hold of EX, and a saturating counter
// of stall cycles. Outputs are combinational from state and inputs so a
// stall takes effect in the same cycle it is detected.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input logic                    Clk,
    input logic                    Rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    // Hold counter only needs to reach MD_LATENCY-2.
    localparam int                MDC_W      = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
    localparam bit                MD_HOLD_EN = (MD_LATENCY > 1);
    localparam logic [MDC_W-1:0]  MD_LOAD    = MDC_W'((MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0);
    localparam logic [CNT_W-1:0]  SC_MAX     = {CNT_W{1'b1}};

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic [MDC_W-1:0]  md_cnt_q;
    logic [MDC_W-1:0]  md_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic              hazard_s;
    logic              stall_s;
    logic              pc_write_s;
    logic              if_id_write_s;
    logic              if_id_flush_s;
    logic              id_ex_bubble_s;
    logic              ex_hold_s;
    logic              busy_s;

    load_use_detect u_load_use_detect (
        .id_rs_i        (bus.ID_rs),
        .id_rt_i        (bus.ID_rt),
        .id_uses_rt_i   (bus.ID_UsesRt),
        .ex_mem_read_i  (bus.EX_MemRead),
        .ex_write_reg_i (bus.EX_WriteReg),
        .hazard_o       (hazard_s)
    );

    // State register: FSM state and remaining mult/div hold cycles.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= {MDC_W{1'b0}};
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state logic: enter MD_WAIT on a mult/div, count down, then release.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.EX_BranchTaken) begin
                    state_d = RUN;
                end else if (bus.EX_MulDiv && MD_HOLD_EN) begin
                    state_d  = MD_WAIT;
                    md_cnt_d = MD_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            MD_WAIT: begin
                // A still-asserted EX_MulDiv on the release cycle is the same
                // op, so it does not re-arm the hold.
                if (md_cnt_q != {MDC_W{1'b0}}) begin
                    state_d  = MD_WAIT;
                    md_cnt_d = md_cnt_q - MDC_W'(1);
                end else begin
                    state_d  = RUN;
                    md_cnt_d = {MDC_W{1'b0}};
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = {MDC_W{1'b0}};
            end
        endcase
    end

    // Output decode: reset squashes everything; otherwise branch > mult/div > load-use.
    always_comb begin
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        ex_hold_s      = 1'b0;
        busy_s         = 1'b0;
        stall_s        = 1'b0;
        if (!Rst_n) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.EX_BranchTaken) begin
                        // Wrong-path instruction in ID is squashed, so any
                        // load-use match against it is moot.
                        if_id_flush_s  = 1'b1;
                        id_ex_bubble_s = 1'b1;
                    end else if (bus.EX_MulDiv && MD_HOLD_EN) begin
                        pc_write_s    = 1'b0;
                        if_id_write_s = 1'b0;
                        ex_hold_s     = 1'b1;
                        stall_s       = 1'b1;
                    end else if (hazard_s) begin
                        pc_write_s     = 1'b0;
                        if_id_write_s  = 1'b0;
                        id_ex_bubble_s = 1'b1;
                        stall_s        = 1'b1;
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                MD_WAIT: begin
                    // Busy covers the holding cycles; the release cycle looks
                    // exactly like normal issue.
                    if (md_cnt_q != {MDC_W{1'b0}}) begin
                        pc_write_s    = 1'b0;
                        if_id_write_s = 1'b0;
                        ex_hold_s     = 1'b1;
                        busy_s        = 1'b1;
                        stall_s       = 1'b1;
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                default: begin
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    // Saturating stall-cycle increment; flushes are not counted.
    always_comb begin
        if (stall_s && (stall_cnt_q != SC_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PCWrite      = pc_write_s;
    assign bus.IF_ID_Write  = if_id_write_s;
    assign bus.IF_ID_Flush  = if_id_flush_s;
    assign bus.ID_EX_Bubble = id_ex_bubble_s;
    assign bus.EX_Hold      = ex_hold_s;
    assign bus.Busy         = busy_s;
    assign bus.StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share all
// stimulus: a 32-bit counter build and a 4-bit counter build for saturation.
module tb_pipeline_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) if_a ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  if_b ();

    pipeline_hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(32)) u_dut_a (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (if_a)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(4)) u_dut_b (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (if_b)
    );

    typedef struct packed {
        logic        sel;
        logic        pcw;
        logic        ifw;
        logic        flush;
        logic        bub;
        logic        hold;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int chk_total = 0;
    int chk_pass  = 0;

    // Reference model state per instance (index 0 = 32-bit, 1 = 4-bit counter).
    bit          m_wait[2];
    int          m_rem[2];
    logic [31:0] m_sc[2];
    bit          n_wait[2];
    int          n_rem[2];
    logic [31:0] n_sc[2];
    logic [31:0] sc_cap[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_total++;
        if (obs === exp) begin
            chk_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_wait[s] = 1'b0;
            m_rem[s]  = 0;
            m_sc[s]   = 32'd0;
        end
    endtask

    function automatic exp_t model_eval(input int s, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic ut, input logic mr, input logic [4:0] wr,
                                        input logic md, input logic br);
        exp_t e;
        bit   lu;
        bit   stall;
        e.sel   = (s != 0);
        e.pcw   = 1'b1;
        e.ifw   = 1'b1;
        e.flush = 1'b0;
        e.bub   = 1'b0;
        e.hold  = 1'b0;
        e.busy  = 1'b0;
        e.sc    = m_sc[s];
        lu      = mr && (wr != 5'd0) && ((wr == rs) || (ut && (wr == rt)));
        stall   = 1'b0;
        n_wait[s] = m_wait[s];
        n_rem[s]  = m_rem[s];
        if (m_wait[s]) begin
            if (m_rem[s] > 0) begin
                e.pcw = 1'b0; e.ifw = 1'b0; e.hold = 1'b1; e.busy = 1'b1;
                stall = 1'b1;
                n_rem[s] = m_rem[s] - 1;
            end else begin
                n_wait[s] = 1'b0;
            end
        end else if (br) begin
            e.flush = 1'b1; e.bub = 1'b1;
        end else if (md) begin
            e.pcw = 1'b0; e.ifw = 1'b0; e.hold = 1'b1;
            stall = 1'b1;
            n_wait[s] = 1'b1;
            n_rem[s]  = MD_LAT - 2;
        end else if (lu) begin
            e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
            stall = 1'b1;
        end
        n_sc[s] = (stall && (m_sc[s] != sc_cap[s])) ? (m_sc[s] + 32'd1) : m_sc[s];
        return e;
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                         input logic mr, input logic [4:0] wr, input logic md, input logic br);
        if_a.ID_rs = rs; if_a.ID_rt = rt; if_a.ID_UsesRt = ut; if_a.EX_MemRead = mr;
        if_a.EX_WriteReg = wr; if_a.EX_MulDiv = md; if_a.EX_BranchTaken = br;
        if_b.ID_rs = rs; if_b.ID_rt = rt; if_b.ID_UsesRt = ut; if_b.EX_MemRead = mr;
        if_b.EX_WriteReg = wr; if_b.EX_MulDiv = md; if_b.EX_BranchTaken = br;
    endtask

    task automatic compare_out(input exp_t e, input string tag);
        logic        pcw, ifw, flush, bub, hold, busy;
        logic [31:0] sc;
        string       t;
        if (!e.sel) begin
            pcw = if_a.PCWrite; ifw = if_a.IF_ID_Write; flush = if_a.IF_ID_Flush;
            bub = if_a.ID_EX_Bubble; hold = if_a.EX_Hold; busy = if_a.Busy;
            sc  = if_a.StallCount;
            t   = {tag, "[a]"};
        end else begin
            pcw = if_b.PCWrite; ifw = if_b.IF_ID_Write; flush = if_b.IF_ID_Flush;
            bub = if_b.ID_EX_Bubble; hold = if_b.EX_Hold; busy = if_b.Busy;
            sc  = {28'd0, if_b.StallCount};
            t   = {tag, "[b]"};
        end
        check_val({t, ".PCWrite"},      {31'd0, pcw},   {31'd0, e.pcw});
        check_val({t, ".IF_ID_Write"},  {31'd0, ifw},   {31'd0, e.ifw});
        check_val({t, ".IF_ID_Flush"},  {31'd0, flush}, {31'd0, e.flush});
        check_val({t, ".ID_EX_Bubble"}, {31'd0, bub},   {31'd0, e.bub});
        check_val({t, ".EX_Hold"},      {31'd0, hold},  {31'd0, e.hold});
        check_val({t, ".Busy"},         {31'd0, busy},  {31'd0, e.busy});
        check_val({t, ".StallCount"},   sc,             e.sc);
    endtask

    // One pipeline cycle: drive after the edge, compare on the falling edge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                        input logic mr, input logic [4:0] wr, input logic md, input logic br,
                        input string tag);
        drive(rs, rt, ut, mr, wr, md, br);
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back(model_eval(s, rs, rt, ut, mr, wr, md, br));
            tag_q.push_back(tag);
        end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            compare_out(exp_q.pop_front(), tag_q.pop_front());
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            m_wait[s] = n_wait[s];
            m_rem[s]  = n_rem[s];
            m_sc[s]   = n_sc[s];
        end
    endtask

    task automatic check_reset(input string tag);
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            e.sel = (s != 0); e.pcw = 1'b0; e.ifw = 1'b0; e.flush = 1'b1;
            e.bub = 1'b1; e.hold = 1'b0; e.busy = 1'b0; e.sc = 32'd0;
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        while (exp_q.size() > 0) begin
            compare_out(exp_q.pop_front(), tag_q.pop_front());
        end
    endtask

    initial begin
        sc_cap[0] = 32'hFFFF_FFFF;
        sc_cap[1] = 32'd15;
        model_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        #12;
        check_reset("rst_init");
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, "idle");

        // Load-use on rs, then clear.
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, "lu_rs");
        step(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "lu_rs_after");
        // Load-use on rt when rt is a source.
        step(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, "lu_rt");
        step(5'd1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, "lu_rt_after");

        // $0 and unused rt never stall.
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, "lw_r0");
        step(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, "rt_unused");

        // Mult/div held in EX for four cycles.
        for (int i = 0; i < 4; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, $sformatf("md%0d", i));
        end
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "md_done");

        // Taken branch overrides a simultaneous load-use match.
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, "br_lu");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "br_after");

        // Reset while in MD_WAIT with one hold cycle left.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "md_rst0");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "md_rst1");
        check_val("pre_rst_busy", {31'd0, if_a.Busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_reset("rst_hold");
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "post_rst");

        // Drive the 4-bit counter to 14, then three more stalls must hold at 15.
        for (int i = 0; i < 14; i++) begin
            step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, $sformatf("sat%0d", i));
        end
        check_val("sat_at_14", {28'd0, if_b.StallCount}, 32'd14);
        for (int i = 0; i < 3; i++) begin
            step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, $sformatf("sat_top%0d", i));
        end
        check_val("sat_hold", {28'd0, if_b.StallCount}, 32'd15);
        check_val("wide_cnt", if_a.StallCount, 32'd17);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
